// File: rtl/keypress_pkg.sv
// -----------------------------------------------------------------------------
// keypress_pkg
// Shared types and defaults for the keypress event queue.
//   KEY_W_DEF / KEYS_DEF : default keycode width and slot count
//   NO_KEY               : keycode value meaning "no key in this slot"
//   keycode_t            : one keycode at the default width
//   key_event_t          : one queued event {is_release, code}
//                          ("release" is a reserved word, hence is_release)
// -----------------------------------------------------------------------------
package keypress_pkg;

    localparam int KEY_W_DEF = 8;
    localparam int KEYS_DEF  = 4;

    typedef logic [KEY_W_DEF-1:0] keycode_t;

    localparam keycode_t NO_KEY = '0;

    typedef struct packed {
        logic     is_release;
        keycode_t code;
    } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// -----------------------------------------------------------------------------
// key_event_fifo
// Synchronous FIFO of key events with a registered head entry.
//   clk, reset : clock, asynchronous active-high reset
//   i_push     : write i_data (accepted when not full, or when full with a pop)
//   i_data     : event to write
//   i_pop      : advance the head (ignored while empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_count    : exact occupancy 0..DEPTH
//   o_head     : registered copy of the oldest entry (zero while empty)
// Pointers wrap modulo DEPTH (power of two). A push into an empty FIFO is
// visible on the following cycle; there is no bypass path.
// -----------------------------------------------------------------------------
module key_event_fifo
    import keypress_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type ev_t  = key_event_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  ev_t                        i_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output ev_t                        o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    ev_t            r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    ev_t            r_head;

    logic           w_pop;
    logic           w_push;
    logic [CW-1:0]  w_count_nxt;
    ev_t            w_head_nxt;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign w_pop  = i_pop & (r_count != CW'(0));
    assign w_push = i_push & ((r_count != CW'(DEPTH)) | w_pop);

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;
    assign o_head  = r_head;

    // Next occupancy and next head entry.
    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end else begin
            w_count_nxt = r_count;
        end

        if (w_count_nxt == CW'(0)) begin
            w_head_nxt = '0;
        end else if (r_count == CW'(0)) begin
            // Only a push can make an empty FIFO non-empty.
            w_head_nxt = i_data;
        end else if (w_pop) begin
            if (r_count == CW'(1)) begin
                w_head_nxt = i_data;
            end else begin
                w_head_nxt = r_mem[r_rd_ptr + AW'(1)];
            end
        end else begin
            w_head_nxt = r_head;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
        end
    end

endmodule

// File: rtl/keypress_event_queue.sv
// -----------------------------------------------------------------------------
// keypress_event_queue
// Snapshots the packed keycode slots, detects new presses against the previous
// snapshot and queues one event per press in a DEPTH-entry FIFO drained by a
// valid/ready consumer.
//   clk, reset : clock, asynchronous active-high reset
//   sample_en  : capture key_in (ignored while busy)
//   key_in     : KEYS packed keycodes, slot i = key_in[i*KEY_W +: KEY_W]
//   busy       : events of the last sample still being pushed
//   prev_keys  : last accepted snapshot
//   ev_valid / ev_ready / ev_code / ev_release : head event handshake
//   count      : FIFO occupancy
//   overflow   : sticky drop flag, cleared by ovf_clr (a drop wins)
// Build option: define KEYPRESS_RELEASE_EN to also queue release events,
// which drain after the presses of the same sample with ev_release=1.
// Without it ev_release is always 0.
// -----------------------------------------------------------------------------
module keypress_event_queue
    import keypress_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int KEYS  = KEYS_DEF,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_en,
    input  logic [KEYS*KEY_W-1:0]      key_in,
    output logic                       busy,
    output logic [KEYS*KEY_W-1:0]      prev_keys,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [KEY_W-1:0]           ev_code,
    output logic                       ev_release,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    typedef struct packed {
        logic             is_release;
        logic [KEY_W-1:0] code;
    } ev_w_t;

    logic [KEYS*KEY_W-1:0] r_prev_keys;
    logic [KEYS-1:0]       r_press_mask;
    logic                  r_busy;
    logic                  r_overflow;

    logic [KEYS-1:0]       w_new_press;
    logic [KEYS-1:0]       w_press_low;
    logic [KEYS-1:0]       w_press_nxt;
    logic [KEY_W-1:0]      w_press_code;
    logic                  w_busy_nxt;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    ev_w_t                 w_push_ev;
    ev_w_t                 w_head;

`ifdef KEYPRESS_RELEASE_EN
    logic [KEYS*KEY_W-1:0] r_old_keys;
    logic [KEYS-1:0]       r_rel_mask;
    logic [KEYS-1:0]       w_new_rel;
    logic [KEYS-1:0]       w_rel_low;
    logic [KEYS-1:0]       w_rel_nxt;
    logic [KEY_W-1:0]      w_rel_code;
`endif

    // r_busy mirrors "any mask bit set", so a sample is taken only when idle.
    assign w_accept = sample_en & ~r_busy;

    // A slot is a new press when nonzero, absent from the old snapshot and
    // not a repeat of a lower slot of the same sample.
    always_comb begin
        w_new_press = '0;
        for (int i = 0; i < KEYS; i++) begin
            w_new_press[i] = (key_in[i*KEY_W +: KEY_W] != {KEY_W{1'b0}});
            for (int j = 0; j < KEYS; j++) begin
                w_new_press[i] = w_new_press[i] &
                    (key_in[i*KEY_W +: KEY_W] != r_prev_keys[j*KEY_W +: KEY_W]);
            end
            for (int j = 0; j < i; j++) begin
                w_new_press[i] = w_new_press[i] &
                    (key_in[i*KEY_W +: KEY_W] != key_in[j*KEY_W +: KEY_W]);
            end
        end
    end

    // Isolate the lowest pending press (x & -x) and select its keycode.
    assign w_press_low = r_press_mask & (~r_press_mask + KEYS'(1));

    // Keycode of the lowest pending press.
    always_comb begin
        w_press_code = '0;
        for (int i = 0; i < KEYS; i++) begin
            w_press_code = w_press_code |
                ({KEY_W{w_press_low[i]}} & r_prev_keys[i*KEY_W +: KEY_W]);
        end
    end

`ifdef KEYPRESS_RELEASE_EN
    // An old slot is released when nonzero, missing from key_in and not a
    // repeat of a lower old slot.
    always_comb begin
        w_new_rel = '0;
        for (int j = 0; j < KEYS; j++) begin
            w_new_rel[j] = (r_prev_keys[j*KEY_W +: KEY_W] != {KEY_W{1'b0}});
            for (int k = 0; k < KEYS; k++) begin
                w_new_rel[j] = w_new_rel[j] &
                    (r_prev_keys[j*KEY_W +: KEY_W] != key_in[k*KEY_W +: KEY_W]);
            end
            for (int k = 0; k < j; k++) begin
                w_new_rel[j] = w_new_rel[j] &
                    (r_prev_keys[j*KEY_W +: KEY_W] != r_prev_keys[k*KEY_W +: KEY_W]);
            end
        end
    end

    assign w_rel_low = r_rel_mask & (~r_rel_mask + KEYS'(1));

    // Release codes come from the snapshot that preceded the current one.
    always_comb begin
        w_rel_code = '0;
        for (int j = 0; j < KEYS; j++) begin
            w_rel_code = w_rel_code |
                ({KEY_W{w_rel_low[j]}} & r_old_keys[j*KEY_W +: KEY_W]);
        end
    end

    // Next masks: load on accept, else retire one bit, presses before releases.
    always_comb begin
        w_press_nxt = r_press_mask;
        w_rel_nxt   = r_rel_mask;
        if (w_accept) begin
            w_press_nxt = w_new_press;
            w_rel_nxt   = w_new_rel;
        end else if (|r_press_mask) begin
            w_press_nxt = r_press_mask & ~w_press_low;
        end else begin
            w_rel_nxt = r_rel_mask & ~w_rel_low;
        end
        w_busy_nxt = (|w_press_nxt) | (|w_rel_nxt);
    end

    // Event presented to the FIFO this cycle.
    always_comb begin
        w_push = (|r_press_mask) | (|r_rel_mask);
        if (|r_press_mask) begin
            w_push_ev.is_release = 1'b0;
            w_push_ev.code       = w_press_code;
        end else begin
            w_push_ev.is_release = 1'b1;
            w_push_ev.code       = w_rel_code;
        end
    end
`else
    // Next press mask: load on accept, else retire the lowest bit.
    always_comb begin
        w_press_nxt = r_press_mask;
        if (w_accept) begin
            w_press_nxt = w_new_press;
        end else begin
            w_press_nxt = r_press_mask & ~w_press_low;
        end
        w_busy_nxt = |w_press_nxt;
    end

    // Event presented to the FIFO this cycle.
    always_comb begin
        w_push               = |r_press_mask;
        w_push_ev.is_release = 1'b0;
        w_push_ev.code       = w_press_code;
    end
`endif

    // Snapshot, pending masks and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_keys  <= '0;
            r_press_mask <= '0;
            r_busy       <= 1'b0;
`ifdef KEYPRESS_RELEASE_EN
            r_old_keys   <= '0;
            r_rel_mask   <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_prev_keys <= key_in;
`ifdef KEYPRESS_RELEASE_EN
                r_old_keys  <= r_prev_keys;
`endif
            end
            r_press_mask <= w_press_nxt;
            r_busy       <= w_busy_nxt;
`ifdef KEYPRESS_RELEASE_EN
            r_rel_mask   <= w_rel_nxt;
`endif
        end
    end

    // A full FIFO with no simultaneous pop drops the event; the mask bit is
    // retired regardless so the drain never stalls.
    assign w_pop  = ev_ready & ~w_empty;
    assign w_drop = w_push & w_full & ~w_pop;

    // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .ev_t  (ev_w_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_ev),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count),
        .o_head  (w_head)
    );

    assign busy       = r_busy;
    assign prev_keys  = r_prev_keys;
    assign ev_valid   = ~w_empty;
    assign ev_code    = w_head.code;
    assign ev_release = w_head.is_release;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_keypress_event_queue.sv
// -----------------------------------------------------------------------------
// tb_keypress_event_queue
// Self-checking bench for keypress_event_queue (KEY_W=8, KEYS=4, DEPTH=8).
// The reference model keeps the pending events and the FIFO contents as
// queues and advances them once per clock from the observable rules.
// Works with and without KEYPRESS_RELEASE_EN.
// -----------------------------------------------------------------------------
module tb_keypress_event_queue;

    localparam int NK = 4;
    localparam int DP = 8;
    localparam int CW = $clog2(DP+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_en = 1'b0;
    logic [31:0]   key_in = 32'h0;
    logic          busy;
    logic [31:0]   prev_keys;
    logic          ev_valid;
    logic          ev_ready = 1'b0;
    logic [7:0]    ev_code;
    logic          ev_release;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ovf_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [8:0]  m_fifo[$];
    logic [8:0]  m_pend[$];
    logic [31:0] m_prev = 32'h0;
    bit          m_ovf  = 1'b0;

    keypress_event_queue #(.KEY_W(8), .KEYS(NK), .DEPTH(DP)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .key_in     (key_in),
        .busy       (busy),
        .prev_keys  (prev_keys),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_release (ev_release),
        .count      (count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] slot_of(input logic [31:0] v, input int i);
        slot_of = v[i*8 +: 8];
    endfunction

    task automatic model_clear();
        m_fifo.delete();
        m_pend.delete();
        m_prev = 32'h0;
        m_ovf  = 1'b0;
    endtask

    // New codes (first occurrence, not held before), then vanished old codes.
    task automatic model_accept(input logic [31:0] nk);
        logic [7:0] c;
        bit keep;
        for (int i = 0; i < NK; i++) begin
            c = slot_of(nk, i);
            keep = (c != 8'h00);
            for (int j = 0; j < NK; j++) if (slot_of(m_prev, j) == c) keep = 1'b0;
            for (int j = 0; j < i; j++)  if (slot_of(nk, j) == c)     keep = 1'b0;
            if (keep) m_pend.push_back({1'b0, c});
        end
`ifdef KEYPRESS_RELEASE_EN
        for (int j = 0; j < NK; j++) begin
            c = slot_of(m_prev, j);
            keep = (c != 8'h00);
            for (int k = 0; k < NK; k++) if (slot_of(nk, k) == c)     keep = 1'b0;
            for (int k = 0; k < j; k++)  if (slot_of(m_prev, k) == c) keep = 1'b0;
            if (keep) m_pend.push_back({1'b1, c});
        end
`endif
        m_prev = nk;
    endtask

    // One clock edge: advance the model with the inputs held across the edge,
    // then move 1 ns past the edge for sampling and driving.
    task automatic tick();
        bit had, pop, drop;
        logic [8:0] e;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            had  = (m_pend.size() != 0);
            pop  = (m_fifo.size() != 0) && ev_ready;
            drop = 1'b0;
            if (pop) void'(m_fifo.pop_front());
            if (had) begin
                e = m_pend.pop_front();
                if (m_fifo.size() < DP) m_fifo.push_back(e);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (!had && sample_en) model_accept(key_in);
        end
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (m_pend.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: busy=%b expected 0", tag, busy);
        end
    endtask

    task automatic do_sample(input logic [31:0] k, input string tag);
        key_in    = k;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        wait_idle(tag);
    endtask

    task automatic drain_all(input string tag);
        int n;
        n = 0;
        ev_ready = 1'b1;
        while (m_fifo.size() != 0 && n < 3*DP) begin
            tick();
            n++;
        end
        ev_ready = 1'b0;
        n_cmp++;
        if (ev_valid !== 1'b0 || count !== CW'(0)) begin
            n_err++;
            $display("FAIL %s_drain: ev_valid=%b count=%0d expected 0/0", tag, ev_valid, count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({busy, ev_valid, count, overflow, prev_keys, ev_code, ev_release} !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b valid=%b count=%0d ovf=%b prev=%h code=%h rel=%b expected all 0",
                     busy, ev_valid, count, overflow, prev_keys, ev_code, ev_release);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_press();
        key_in = 32'h0000_0004; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        n_cmp++;
        if (ev_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_t1: valid=%b busy=%b expected 0/1", ev_valid, busy);
        end
        tick();
        n_cmp++;
        if ({ev_valid, ev_code, ev_release, count, busy} !== {1'b1, 8'h04, 1'b0, CW'(1), 1'b0}) begin
            n_err++;
            $display("FAIL single_t2: valid=%b code=%h rel=%b count=%0d busy=%b expected 1/04/0/1/0",
                     ev_valid, ev_code, ev_release, count, busy);
        end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        n_cmp++;
        if (count !== CW'(0) || ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pop: count=%0d valid=%b expected 0/0", count, ev_valid);
        end
    endtask

    task automatic test_multi_press();
        key_in = 32'h0016_0704; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL multi_busy1: busy=%b expected 1", busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b1 || ev_code !== 8'h07 || count !== CW'(1)) begin
            n_err++;
            $display("FAIL multi_t2: busy=%b code=%h count=%0d expected 1/07/1", busy, ev_code, count);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || ev_code !== 8'h07 || count !== CW'(2)) begin
            n_err++;
            $display("FAIL multi_t3: busy=%b code=%h count=%0d expected 0/07/2", busy, ev_code, count);
        end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        n_cmp++;
        if (ev_code !== 8'h16 || ev_release !== 1'b0 || count !== CW'(1)) begin
            n_err++;
            $display("FAIL multi_second: code=%h rel=%b count=%0d expected 16/0/1", ev_code, ev_release, count);
        end
        drain_all("multi");
    endtask

    task automatic test_dedupe();
        logic [CW-1:0] exp_cnt;
`ifdef KEYPRESS_RELEASE_EN
        exp_cnt = CW'(4);
`else
        exp_cnt = CW'(1);
`endif
        do_sample(32'h0505_0500, "dedupe");
        n_cmp++;
        if (count !== exp_cnt || ev_code !== 8'h05 || ev_release !== 1'b0) begin
            n_err++;
            $display("FAIL dedupe: count=%0d code=%h rel=%b expected %0d/05/0", count, ev_code, ev_release, exp_cnt);
        end
        drain_all("dedupe");
    endtask

    task automatic test_overflow();
        do_sample(32'h0102_0304, "ovf_a");
        do_sample(32'h0506_0708, "ovf_b");
        do_sample(32'h090a_0b0c, "ovf_c");
        n_cmp++;
        if (count !== CW'(DP) || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_set: count=%0d ovf=%b expected 8/1", count, overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (count !== CW'(DP) || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clr: count=%0d ovf=%b expected 8/0", count, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        int n;
        key_in = 32'h0d0e_0f10; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        ev_ready = 1'b1;
        n = 0;
        while (m_pend.size() != 0 && n < 20) begin
            tick();
            n++;
            n_cmp++;
            if (count !== CW'(DP) || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL full_push_pop: count=%0d ovf=%b expected 8/0", count, overflow);
            end
        end
        n = 0;
        while (m_fifo.size() != 0 && n < 3*DP) begin
            n_cmp++;
            if ({ev_release, ev_code} !== m_fifo[0]) begin
                n_err++;
                $display("FAIL wrap_order: head=%h expected %h", {ev_release, ev_code}, m_fifo[0]);
            end
            tick();
            n++;
        end
        ev_ready = 1'b0;
        n_cmp++;
        if (ev_valid !== 1'b0) begin
            n_err++; $display("FAIL wrap_empty: valid=%b expected 0", ev_valid);
        end
    endtask

    task automatic test_release();
        do_sample(32'h0000_0704, "rel_setup");
        drain_all("rel_setup");
        do_sample(32'h0000_0004, "rel");
        n_cmp++;
`ifdef KEYPRESS_RELEASE_EN
        if ({ev_valid, count, ev_code, ev_release} !== {1'b1, CW'(1), 8'h07, 1'b1}) begin
            n_err++;
            $display("FAIL release_event: valid=%b count=%0d code=%h rel=%b expected 1/1/07/1",
                     ev_valid, count, ev_code, ev_release);
        end
`else
        if (ev_valid !== 1'b0 || count !== CW'(0)) begin
            n_err++;
            $display("FAIL release_none: valid=%b count=%0d expected 0/0", ev_valid, count);
        end
`endif
        drain_all("rel");
    endtask

    task automatic test_reset_midop();
        key_in = 32'h0a0b_0c0d; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (count !== CW'(3) || busy !== 1'b1 || prev_keys !== 32'h0a0b_0c0d) begin
            n_err++;
            $display("FAIL midop_pre: count=%0d busy=%b prev=%h expected 3/1/0a0b0c0d", count, busy, prev_keys);
        end
        #1 reset = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (ev_valid !== 1'b0 || busy !== 1'b0 || prev_keys !== 32'h0 || count !== CW'(0)) begin
            n_err++;
            $display("FAIL midop_reset: valid=%b busy=%b prev=%h count=%0d expected 0/0/0/0",
                     ev_valid, busy, prev_keys, count);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [47:0] obs, exp;
        logic [8:0]  exp_head, obs_head;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            sample_en = ($urandom_range(0, 2) == 0);
            for (int s = 0; s < NK; s++) key_in[s*8 +: 8] = 8'($urandom_range(0, 5));
            ev_ready  = (cyc < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            tick();
            exp_head = (m_fifo.size() != 0) ? m_fifo[0] : 9'h0;
            obs_head = (m_fifo.size() != 0) ? {ev_release, ev_code} : 9'h0;
            exp = {(m_pend.size() != 0), (m_fifo.size() != 0), CW'(m_fifo.size()), m_ovf, m_prev, exp_head};
            obs = {busy, ev_valid, count, overflow, prev_keys, obs_head};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random cyc %0d: got busy/valid/count/ovf/prev/head=%h expected %h", cyc, obs, exp);
            end
        end
        sample_en = 1'b0;
        ovf_clr   = 1'b0;
        wait_idle("random");
        drain_all("random");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_multi_press();
        test_dedupe();
        test_overflow();
        test_full_push_pop();
        test_release();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
